// File: rtl/subtractor_two.sv
`default_nettype none
// ============================================================================
// Module   : subtractor_two
// Brief    : Bit-serial (WIDTH+1)-bit subtractor, out = sum - in1, with
//            start/done handshake and underflow/overflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module subtractor_two #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH:0]   sum,
   input  logic [WIDTH-1:0] in1,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             underflow,
   output logic             overflow
);

   localparam int                 c_cnt_w = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [c_cnt_w-1:0] r_count;
   logic [WIDTH:0]     r_a;
   logic [WIDTH:0]     r_b;
   logic [WIDTH-1:0]   r_result;
   logic               r_borrow;

   logic w_accept;
   logic w_step;
   logic w_last;
   logic w_a;
   logic w_b;
   logic w_d;
   logic w_bout;

   // Operands are shifted right, so the active bit is always at position 0.
   assign w_a    = r_a[0];
   assign w_b    = r_b[0];
   assign w_d    = w_a ^ w_b ^ r_borrow;
   assign w_bout = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);

   always_comb begin
      w_next   = r_state;
      busy     = 1'b0;
      done     = 1'b0;
      w_accept = 1'b0;
      w_step   = 1'b0;
      w_last   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept = 1'b1;
               w_next   = S_RUN;
            end
         end
         S_RUN: begin
            busy   = 1'b1;
            w_step = 1'b1;
            if (r_count == c_last) begin
               w_last = 1'b1;
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_count   <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_result  <= '0;
         r_borrow  <= 1'b0;
         out       <= '0;
         underflow <= 1'b0;
         overflow  <= 1'b0;
      end else if (w_accept) begin
         r_count  <= '0;
         r_a      <= sum;
         r_b      <= {1'b0, in1};
         r_result <= '0;
         r_borrow <= 1'b0;
      end else if (w_step) begin
         r_a      <= {1'b0, r_a[WIDTH:1]};
         r_b      <= {1'b0, r_b[WIDTH:1]};
         r_result <= {w_d, r_result[WIDTH-1:1]};
         r_borrow <= w_bout;
         if (w_last) begin
            // On the final step r_result already holds difference bits [WIDTH-1:0];
            // w_d is bit WIDTH and w_bout the final borrow.
            r_count   <= '0;
            out       <= r_result;
            underflow <= w_bout;
            overflow  <= ~w_bout & w_d;
         end else begin
            r_count <= r_count + c_cnt_w'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_subtractor_two.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtractor_two
// Brief    : Directed, table-driven bench for subtractor_two (WIDTH=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_subtractor_two;

   localparam int WIDTH = 10;

   logic             clk;
   logic             resetn;
   logic             start;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] in1;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             underflow;
   logic             overflow;

   int errors = 0;
   int checks = 0;

   subtractor_two #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start     (start),
      .sum       (sum),
      .in1       (in1),
      .busy      (busy),
      .done      (done),
      .out       (out),
      .underflow (underflow),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH:0]   s;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] exp_out;
      logic             exp_uf;
      logic             exp_of;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Returns the cycle index (1 = first cycle after acceptance) at which done
   // was seen, or -1 on timeout; leaves the caller on the done cycle's negedge.
   task automatic run_op(input logic [WIDTH:0] s, input logic [WIDTH-1:0] a,
                         output int lat, output int bcnt);
      @(negedge clk);
      sum   = s;
      in1   = a;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat   = -1;
      bcnt  = 0;
      for (int k = 1; k <= 30; k++) begin
         if (busy) bcnt++;
         if (done) begin
            lat = k;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int lat;
      int bcnt;
      int ndone;
      int first_cyc;
      int d_cyc[3];
      int unstable;

      vecs[0] = '{11'd1000, 10'd1,    10'd999,  1'b0, 1'b0};
      vecs[1] = '{11'd2046, 10'd1023, 10'd1023, 1'b0, 1'b0};
      vecs[2] = '{11'd2046, 10'd0,    10'd1022, 1'b0, 1'b1};
      vecs[3] = '{11'd5,    10'd6,    10'd1023, 1'b1, 1'b0};
      vecs[4] = '{11'd0,    10'd0,    10'd0,    1'b0, 1'b0};
      vecs[5] = '{11'd2047, 10'd0,    10'd1023, 1'b0, 1'b1};
      vecs[6] = '{11'd1024, 10'd0,    10'd0,    1'b0, 1'b1};
      vecs[7] = '{11'd0,    10'd1023, 10'd1,    1'b1, 1'b0};
      vecs[8] = '{11'd1000, 10'd1,    10'd999,  1'b0, 1'b0};

      resetn = 1'b0;
      start  = 1'b0;
      sum    = '0;
      in1    = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_out",  int'(out), 0);
      check("reset_uf",   int'(underflow), 0);
      check("reset_of",   int'(overflow), 0);
      resetn = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].s, vecs[i].a, lat, bcnt);
         check($sformatf("v%0d_latency", i), lat, 12);
         check($sformatf("v%0d_busy_cycles", i), bcnt, 11);
         check($sformatf("v%0d_out", i), int'(out), int'(vecs[i].exp_out));
         check($sformatf("v%0d_uf", i), int'(underflow), int'(vecs[i].exp_uf));
         check($sformatf("v%0d_of", i), int'(overflow), int'(vecs[i].exp_of));
         @(negedge clk);
         check($sformatf("v%0d_done_1cyc", i), int'(done), 0);
         check($sformatf("v%0d_idle", i), int'(busy), 0);
      end

      // Start pulsed mid-RUN with other operands must be ignored.
      @(negedge clk);
      sum   = 11'd1000;
      in1   = 10'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int k = 1; k <= 25; k++) begin
         if (k == 4) begin
            sum   = 11'd50;
            in1   = 10'd20;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (done) begin
            ndone++;
            check("ignore_latency", k, 12);
            check("ignore_out", int'(out), 999);
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("ignore_done_count", ndone, 1);

      // Asynchronous reset in the middle of RUN aborts the operation.
      @(negedge clk);
      sum   = 11'd700;
      in1   = 10'd100;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_out",  int'(out), 0);
      check("abort_uf",   int'(underflow), 0);
      check("abort_of",   int'(overflow), 0);
      @(negedge clk);
      resetn = 1'b1;
      ndone  = 0;
      bcnt   = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) ndone++;
         if (busy) bcnt++;
      end
      check("abort_no_done", ndone, 0);
      check("abort_stays_idle", bcnt, 0);
      run_op(11'd300, 10'd45, lat, bcnt);
      check("post_reset_latency", lat, 12);
      check("post_reset_out", int'(out), 255);
      check("post_reset_flags", int'({underflow, overflow}), 0);

      // Start held high: back-to-back operations every WIDTH+3 cycles.
      @(negedge clk);
      @(negedge clk);
      sum      = 11'd100;
      in1      = 10'd40;
      start    = 1'b1;
      ndone    = 0;
      first_cyc = -1;
      unstable = 0;
      for (int k = 1; k <= 60 && ndone < 3; k++) begin
         @(negedge clk);
         if (first_cyc >= 0 && out != 10'd60) unstable++;
         if (done) begin
            d_cyc[ndone] = k;
            if (first_cyc < 0) first_cyc = k;
            check($sformatf("held_out_%0d", ndone), int'(out), 60);
            ndone++;
         end
      end
      start = 1'b0;
      check("held_done_count", ndone, 3);
      if (ndone == 3) begin
         check("held_period_1", d_cyc[1] - d_cyc[0], 13);
         check("held_period_2", d_cyc[2] - d_cyc[1], 13);
      end
      check("held_out_stable", unstable, 0);
      repeat (15) @(negedge clk);
      check("held_end_idle", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
